// File: rtl/adv_usb_packer_if.sv
// Bus bundle for adv_usb_packer: decoder pixel inputs plus the FT60x-style
// write side. The master modport is the packer; the slave modport is the
// environment (decoder and USB FIFO chip).
interface adv_usb_packer_if #(
    parameter int PIX_W = 16,
    parameter int BUS_W = 32
);
    logic               vs;
    logic               de;
    logic [PIX_W-1:0]   pix;
    logic               txe_n;
    logic [BUS_W-1:0]   data;
    logic [BUS_W/8-1:0] be;
    logic               wr_n;

    modport master (input vs, de, pix, txe_n, output data, be, wr_n);
    modport slave  (output vs, de, pix, txe_n, input data, be, wr_n);
endinterface

// File: rtl/adv_usb_packer.sv
// adv_usb_packer: packs PIX_W pixels into BUS_W words, prefixes every frame
// with a header word, buffers words in a FIFO and drains them through an
// FT60x-style write port. Overflow truncates the current frame and is counted.
module adv_usb_packer #(
    parameter int          PIX_W     = 16,
    parameter int          BUS_W     = 32,
    parameter int          FIFO_AW   = 9,
    parameter int          VS_POL    = 1,
    parameter logic [15:0] HDR_MAGIC = 16'hA5A5
) (
    input  logic               CLK,
    input  logic               rst,
    input  logic               enable,
    adv_usb_packer_if.master   bus,
    output logic [15:0]        frame_cnt,
    output logic [15:0]        ovf_cnt,
    output logic [FIFO_AW:0]   fifo_level
);
    localparam int   PPW    = BUS_W / PIX_W;
    localparam int   BEW    = BUS_W / 8;
    localparam int   BPP    = PIX_W / 8;
    localparam int   DEPTH  = 1 << FIFO_AW;
    localparam int   CNT_W  = $clog2(PPW + 1);
    localparam logic VS_ACT = (VS_POL != 0);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HEADER = 3'd1;
    localparam logic [2:0] S_ACTIVE = 3'd2;
    localparam logic [2:0] S_FLUSH  = 3'd3;
    localparam logic [2:0] S_DROP   = 3'd4;

    // ---------------- frame boundary detection ----------------
    logic vs_q, vs_qq, fb;

    // Two-stage vs history; fb is the first registered cycle at the active level.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            vs_q  <= ~VS_ACT;
            vs_qq <= ~VS_ACT;
        end else begin
            vs_q  <= bus.vs;
            vs_qq <= vs_q;
        end
    end

    assign fb = (vs_q == VS_ACT) && (vs_qq != VS_ACT);

    // ---------------- capture FSM and packer ----------------
    logic [2:0]       state_q, state_d;
    logic [BUS_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      frame_q, frame_d;
    logic [15:0]      ovf_q;
    logic             ovf_bump;
    logic             push_req, push_en, can_push;
    logic [BUS_W-1:0] push_data;
    logic [BEW-1:0]   push_be;
    logic [BUS_W-1:0] packed_word;
    logic [BEW-1:0]   flush_be;

    // Accumulated pixels with the incoming pixel dropped into the next slot,
    // and the byte-enable mask covering the pixels already held.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so
        // no path leaves it unassigned and no latch is inferred.
        packed_word = acc_q;
        packed_word[int'(cnt_q)*PIX_W +: PIX_W] = bus.pix;
        flush_be = '0;
        for (int i = 0; i < BEW; i++) begin
            flush_be[i] = (i < int'(cnt_q) * BPP);
        end
    end

    // Next-state logic: framing, packing and the push request into the FIFO.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        frame_d   = frame_q;
        ovf_bump  = 1'b0;
        push_req  = 1'b0;
        push_data = '0;
        push_be   = '0;
        case (state_q)
            S_IDLE: begin
                if (fb && enable) state_d = S_HEADER;
            end
            S_HEADER: begin
                push_req  = 1'b1;
                push_data = (BUS_W'(HDR_MAGIC) << 16) | BUS_W'(frame_q);
                push_be   = '1;
                acc_d     = '0;
                cnt_d     = '0;
                if (can_push) begin
                    frame_d = frame_q + 16'd1;
                    state_d = S_ACTIVE;
                end else begin
                    ovf_bump = 1'b1;
                    state_d  = S_DROP;
                end
            end
            S_ACTIVE: begin
                if (fb) begin
                    if (cnt_q != '0) state_d = S_FLUSH;
                    else             state_d = enable ? S_HEADER : S_IDLE;
                end else if (bus.de) begin
                    if (cnt_q == CNT_W'(PPW - 1)) begin
                        push_req  = 1'b1;
                        push_data = packed_word;
                        push_be   = '1;
                        acc_d     = '0;
                        cnt_d     = '0;
                        if (!can_push) begin
                            ovf_bump = 1'b1;
                            state_d  = S_DROP;
                        end
                    end else begin
                        acc_d = packed_word;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_FLUSH: begin
                push_req  = 1'b1;
                push_data = acc_q;
                push_be   = flush_be;
                acc_d     = '0;
                cnt_d     = '0;
                if (!can_push) ovf_bump = 1'b1;
                state_d   = enable ? S_HEADER : S_IDLE;
            end
            S_DROP: begin
                acc_d = '0;
                cnt_d = '0;
                if (fb) state_d = enable ? S_HEADER : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM, packer and counter registers; the overflow counter saturates.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            frame_q <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            if (ovf_bump && (ovf_q != 16'hFFFF)) ovf_q <= ovf_q + 16'd1;
        end
    end

    // ---------------- word FIFO ----------------
    logic [BUS_W-1:0]   mem_data [DEPTH];
    logic [BEW-1:0]     mem_be   [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   level_q;
    logic               push_q;
    logic               readable, pop, xfer, full;
    logic [BUS_W-1:0]   data_q;
    logic [BEW-1:0]     be_q;
    logic               out_vld_q;

    // A word becomes readable one cycle after its write, giving a two-edge
    // push-to-strobe latency; a pop on a full FIFO frees the slot for a push.
    assign xfer     = out_vld_q && !bus.txe_n;
    assign readable = level_q > (FIFO_AW+1)'(push_q);
    assign pop      = readable && (!out_vld_q || xfer);
    assign full     = (level_q == (FIFO_AW+1)'(DEPTH));
    assign can_push = !full || pop;
    assign push_en  = push_req && can_push;

    // Storage array write port.
    always_ff @(posedge CLK) begin
        // NOTE: the storage array has no reset; the pointers and level define
        // which entries are valid, so stale contents are never observed.
        if (push_en) begin
            mem_data[wr_ptr_q] <= push_data;
            mem_be[wr_ptr_q]   <= push_be;
        end
    end

    // FIFO pointers, occupancy and the just-written marker.
    always_ff @(posedge CLK) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            push_q   <= 1'b0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            level_q <= level_q + (FIFO_AW+1)'(push_en) - (FIFO_AW+1)'(pop);
            push_q  <= push_en;
        end
    end

    // Output register: holds a word until the USB side accepts it.
    always_ff @(posedge CLK) begin
        if (rst) begin
            data_q    <= '0;
            be_q      <= '0;
            out_vld_q <= 1'b0;
        end else if (pop) begin
            data_q    <= mem_data[rd_ptr_q];
            be_q      <= mem_be[rd_ptr_q];
            out_vld_q <= 1'b1;
        end else if (xfer) begin
            out_vld_q <= 1'b0;
        end
    end

    assign bus.data   = data_q;
    assign bus.be     = be_q;
    assign bus.wr_n   = ~out_vld_q;
    assign frame_cnt  = frame_q;
    assign ovf_cnt    = ovf_q;
    assign fifo_level = level_q;
endmodule

// File: tb/tb_adv_usb_packer.sv
// Self-checking bench for adv_usb_packer: a 32-bit instance with an 8-deep
// FIFO and a 64-bit instance, each checked against a queue of expected words.
module tb_adv_usb_packer;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        rst;
    logic        en32, en64;
    logic [15:0] fc32, oc32, fc64, oc64;
    logic [3:0]  lv32;
    logic [4:0]  lv64;

    adv_usb_packer_if #(.PIX_W(16), .BUS_W(32)) b32 ();
    adv_usb_packer_if #(.PIX_W(16), .BUS_W(64)) b64 ();

    adv_usb_packer #(.PIX_W(16), .BUS_W(32), .FIFO_AW(3)) u_dut32 (
        .CLK(CLK), .rst(rst), .enable(en32), .bus(b32),
        .frame_cnt(fc32), .ovf_cnt(oc32), .fifo_level(lv32));

    adv_usb_packer #(.PIX_W(16), .BUS_W(64), .FIFO_AW(4)) u_dut64 (
        .CLK(CLK), .rst(rst), .enable(en64), .bus(b64),
        .frame_cnt(fc64), .ovf_cnt(oc64), .fifo_level(lv64));

    typedef struct packed { logic [31:0] d; logic [3:0] b; } w32_t;
    typedef struct packed { logic [63:0] d; logic [7:0] b; } w64_t;
    w32_t q32[$];
    w64_t q64[$];
    w32_t e32;
    w64_t e64;
    int total = 0;
    int bad   = 0;

    // Scoreboards: a transfer happens at the next rising edge when wr_n and txe_n are low.
    always @(negedge CLK) begin
        if (rst === 1'b0 && b32.wr_n === 1'b0 && b32.txe_n === 1'b0) begin
            total++;
            if (q32.size() == 0) begin
                bad++;
                $display("FAIL out32 unexpected word data=%h be=%h", b32.data, b32.be);
            end else begin
                e32 = q32.pop_front();
                if (b32.data !== e32.d || b32.be !== e32.b) begin
                    bad++;
                    $display("FAIL out32 word got data=%h be=%h want data=%h be=%h",
                             b32.data, b32.be, e32.d, e32.b);
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (rst === 1'b0 && b64.wr_n === 1'b0 && b64.txe_n === 1'b0) begin
            total++;
            if (q64.size() == 0) begin
                bad++;
                $display("FAIL out64 unexpected word data=%h be=%h", b64.data, b64.be);
            end else begin
                e64 = q64.pop_front();
                if (b64.data !== e64.d || b64.be !== e64.b) begin
                    bad++;
                    $display("FAIL out64 word got data=%h be=%h want data=%h be=%h",
                             b64.data, b64.be, e64.d, e64.b);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic fb32();
        b32.vs = 1'b1; tick(1); b32.vs = 1'b0; tick(3);
    endtask

    task automatic fb64();
        b64.vs = 1'b1; tick(1); b64.vs = 1'b0; tick(3);
    endtask

    task automatic pix32(input logic [15:0] v);
        b32.de = 1'b1; b32.pix = v; tick(1); b32.de = 1'b0;
    endtask

    task automatic pix64(input logic [15:0] v);
        b64.de = 1'b1; b64.pix = v; tick(1); b64.de = 1'b0;
    endtask

    task automatic exp32(input logic [31:0] d, input logic [3:0] b);
        q32.push_back({d, b});
    endtask

    task automatic exp64(input logic [63:0] d, input logic [7:0] b);
        q64.push_back({d, b});
    endtask

    task automatic drain32(input string tag);
        int n = 0;
        while ((q32.size() != 0 || lv32 != 0 || b32.wr_n !== 1'b1) && n < 300) begin
            tick(1); n++;
        end
        total++;
        if (n >= 300) begin
            bad++;
            $display("FAIL %s drain32 timeout pending=%0d level=%0d want pending=0", tag, q32.size(), lv32);
        end
    endtask

    task automatic drain64(input string tag);
        int n = 0;
        while ((q64.size() != 0 || lv64 != 0 || b64.wr_n !== 1'b1) && n < 300) begin
            tick(1); n++;
        end
        total++;
        if (n >= 300) begin
            bad++;
            $display("FAIL %s drain64 timeout pending=%0d level=%0d want pending=0", tag, q64.size(), lv64);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(2);
        total += 6;
        if (b32.wr_n !== 1'b1)  begin bad++; $display("FAIL reset wr_n got=%b want=1", b32.wr_n); end
        if (b32.data !== 32'h0) begin bad++; $display("FAIL reset data got=%h want=0", b32.data); end
        if (b32.be !== 4'h0)    begin bad++; $display("FAIL reset be got=%h want=0", b32.be); end
        if (fc32 !== 16'h0)     begin bad++; $display("FAIL reset frame_cnt got=%h want=0", fc32); end
        if (oc32 !== 16'h0)     begin bad++; $display("FAIL reset ovf_cnt got=%h want=0", oc32); end
        if (lv32 !== 4'h0)      begin bad++; $display("FAIL reset level got=%0d want=0", lv32); end
        rst = 1'b0; tick(1);
    endtask

    task automatic test_basic();
        en32 = 1'b1; b32.txe_n = 1'b0;
        exp32(32'hA5A5_0000, 4'hF);
        exp32(32'h0002_0001, 4'hF);
        exp32(32'h0004_0003, 4'hF);
        fb32();
        for (int i = 1; i <= 4; i++) pix32(16'(i));
        drain32("basic");
        total++;
        if (fc32 !== 16'd1) begin bad++; $display("FAIL basic frame_cnt got=%0d want=1", fc32); end
    endtask

    task automatic test_partial();
        exp32(32'h00BB_00AA, 4'hF);
        exp32(32'h0000_00CC, 4'h3);
        exp32(32'hA5A5_0001, 4'hF);
        pix32(16'hAA); pix32(16'hBB); pix32(16'hCC);
        fb32();
        drain32("partial");
        total += 2;
        if (fc32 !== 16'd2) begin bad++; $display("FAIL partial frame_cnt got=%0d want=2", fc32); end
        if (oc32 !== 16'd0) begin bad++; $display("FAIL partial ovf_cnt got=%0d want=0", oc32); end
    endtask

    task automatic test_backpressure();
        b32.txe_n = 1'b1;
        for (int i = 0; i < 6; i += 2) exp32({16'h3001 + 16'(i), 16'h3000 + 16'(i)}, 4'hF);
        for (int i = 0; i < 6; i++) pix32(16'h3000 + 16'(i));
        tick(4);
        total++;
        if (lv32 !== 4'd2) begin bad++; $display("FAIL backpressure level got=%0d want=2", lv32); end
        for (int c = 0; c < 20; c++) begin
            total++;
            if (b32.wr_n !== 1'b0 || b32.data !== 32'h3001_3000) begin
                bad++;
                $display("FAIL backpressure hold cycle=%0d wr_n=%b data=%h want wr_n=0 data=30013000",
                         c, b32.wr_n, b32.data);
            end
            tick(1);
        end
        b32.txe_n = 1'b0;
        drain32("backpressure");
    endtask

    task automatic test_overflow();
        b32.txe_n = 1'b1;
        exp32(32'hA5A5_0002, 4'hF);
        fb32();
        for (int i = 0; i < 40; i++) begin
            pix32(16'h4000 + 16'(i));
            if ((i % 2) == 1 && (i / 2) < 8) exp32({16'h4000 + 16'(i), 16'h4000 + 16'(i - 1)}, 4'hF);
        end
        tick(2);
        total += 4;
        if (lv32 !== 4'd8)  begin bad++; $display("FAIL overflow level got=%0d want=8", lv32); end
        if (oc32 !== 16'd1) begin bad++; $display("FAIL overflow ovf_cnt got=%0d want=1", oc32); end
        if (fc32 !== 16'd3) begin bad++; $display("FAIL overflow frame_cnt got=%0d want=3", fc32); end
        if (b32.wr_n !== 1'b0 || b32.data !== 32'hA5A5_0002) begin
            bad++; $display("FAIL overflow held wr_n=%b data=%h want wr_n=0 data=a5a50002", b32.wr_n, b32.data);
        end
        b32.txe_n = 1'b0;
        drain32("overflow");
        exp32(32'hA5A5_0003, 4'hF);
        exp32(32'h4101_4100, 4'hF);
        fb32();
        pix32(16'h4100); pix32(16'h4101);
        drain32("overflow_next");
        total += 2;
        if (fc32 !== 16'd4) begin bad++; $display("FAIL overflow_next frame_cnt got=%0d want=4", fc32); end
        if (oc32 !== 16'd1) begin bad++; $display("FAIL overflow_next ovf_cnt got=%0d want=1", oc32); end
    endtask

    task automatic test_enable_reset();
        en32 = 1'b0;
        exp32(32'h5001_5000, 4'hF);
        exp32(32'h0000_5002, 4'h3);
        pix32(16'h5000); pix32(16'h5001); pix32(16'h5002);
        fb32();
        drain32("enable_off");
        fb32();
        pix32(16'h5555); pix32(16'h5556);
        tick(5);
        total += 3;
        if (fc32 !== 16'd4)   begin bad++; $display("FAIL idle frame_cnt got=%0d want=4", fc32); end
        if (lv32 !== 4'd0)    begin bad++; $display("FAIL idle level got=%0d want=0", lv32); end
        if (b32.wr_n !== 1'b1) begin bad++; $display("FAIL idle wr_n got=%b want=1", b32.wr_n); end
        en32 = 1'b1; b32.txe_n = 1'b1;
        fb32();
        pix32(16'h5100); pix32(16'h5101);
        tick(3);
        total++;
        if (b32.wr_n !== 1'b0) begin bad++; $display("FAIL prereset wr_n got=%b want=0", b32.wr_n); end
        rst = 1'b1; q32.delete(); tick(1);
        total += 4;
        if (b32.wr_n !== 1'b1) begin bad++; $display("FAIL midreset wr_n got=%b want=1", b32.wr_n); end
        if (lv32 !== 4'd0)     begin bad++; $display("FAIL midreset level got=%0d want=0", lv32); end
        if (fc32 !== 16'd0)    begin bad++; $display("FAIL midreset frame_cnt got=%0d want=0", fc32); end
        if (oc32 !== 16'd0)    begin bad++; $display("FAIL midreset ovf_cnt got=%0d want=0", oc32); end
        rst = 1'b0; b32.txe_n = 1'b0; tick(1);
        exp32(32'hA5A5_0000, 4'hF);
        exp32(32'h6001_6000, 4'hF);
        fb32();
        pix32(16'h6000); pix32(16'h6001);
        drain32("after_reset");
        total++;
        if (fc32 !== 16'd1) begin bad++; $display("FAIL after_reset frame_cnt got=%0d want=1", fc32); end
    endtask

    task automatic test_bus64();
        en64 = 1'b1; b64.txe_n = 1'b0;
        exp64(64'h0000_0000_A5A5_0000, 8'hFF);
        exp64(64'h0004_0003_0002_0001, 8'hFF);
        exp64(64'h0000_0000_0000_0005, 8'h03);
        exp64(64'h0000_0000_A5A5_0001, 8'hFF);
        fb64();
        for (int i = 1; i <= 5; i++) pix64(16'(i));
        fb64();
        drain64("bus64");
        total += 2;
        if (fc64 !== 16'd2) begin bad++; $display("FAIL bus64 frame_cnt got=%0d want=2", fc64); end
        if (oc64 !== 16'd0) begin bad++; $display("FAIL bus64 ovf_cnt got=%0d want=0", oc64); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en32 = 1'b0; en64 = 1'b0;
        b32.vs = 1'b0; b32.de = 1'b0; b32.pix = '0; b32.txe_n = 1'b1;
        b64.vs = 1'b0; b64.de = 1'b0; b64.pix = '0; b64.txe_n = 1'b1;
        test_reset();
        test_basic();
        test_partial();
        test_backpressure();
        test_overflow();
        test_enable_reset();
        test_bus64();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
